// File: rtl/s1_serial_tx_pkg.sv
// Shared definitions for the S1 serial transmitter and the S2 side that decodes its frames:
// field widths, run length, default timing and FSM state encodings.
package s1_serial_tx_pkg;

   localparam int DEF_ADDR_W    = 3;
   localparam int DEF_DATA_W    = 18;
   localparam int DEF_FRAME_W   = DEF_ADDR_W + DEF_DATA_W;
   localparam int DEF_NUM_WORDS = 8;
   localparam int DEF_GAP_CYC   = 2;
   localparam int DEF_RD_WAIT   = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/s1_serial_tx_piso.sv
// Parallel-load, shift-left register; zeros fill from the LSB so the MSB idles low once a
// frame has been fully shifted out.
module s1_serial_tx_piso
   import s1_serial_tx_pkg::*;
#(
   parameter int FRAME_W = DEF_FRAME_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               shift_en,
   input  logic [FRAME_W-1:0] din,
   output logic               msb
);

   logic [FRAME_W-1:0] shreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
      end else if (load) begin
         shreg <= din;
      end else if (shift_en) begin
         shreg <= {shreg[FRAME_W-2:0], 1'b0};
      end
   end

   assign msb = shreg[FRAME_W-1];

endmodule

// File: rtl/s1_serial_tx.sv
// Reads NUM_WORDS words from RB1 and sends each as an {address, data} frame on sen/sd,
// MSB first with sen low, followed by a sen-high gap; raises S1_done after the last gap.
module s1_serial_tx
   import s1_serial_tx_pkg::*;
#(
   parameter int NUM_WORDS = DEF_NUM_WORDS,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int GAP_CYC   = DEF_GAP_CYC,
   parameter int RD_WAIT   = DEF_RD_WAIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] RB1_Q,
   output logic              RB1_RW,
   output logic [ADDR_W-1:0] RB1_A,
   output logic              sen,
   output logic              sd,
   output logic              S1_done
);

   localparam int FRAME_W  = ADDR_W + DATA_W;
   localparam int CNT_W    = $clog2(FRAME_W);
   localparam int WAIT_MAX = (RD_WAIT > GAP_CYC) ? RD_WAIT : GAP_CYC;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

   state_t            state, state_nx;
   logic [ADDR_W:0]   word_idx, word_idx_nx, word_inc;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
   logic              load, shift_en;

   assign RB1_RW   = 1'b1;
   assign word_inc = word_idx + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         word_idx <= '0;
         bit_cnt  <= '0;
         wait_cnt <= '0;
         RB1_A    <= '0;
         sen      <= 1'b1;
         S1_done  <= 1'b0;
      end else begin
         state    <= state_nx;
         word_idx <= word_idx_nx;
         bit_cnt  <= bit_cnt_nx;
         wait_cnt <= wait_cnt_nx;
         // Outputs follow the state being entered so they change on the transition edge.
         RB1_A    <= (state_nx == ST_DONE) ? '0 : word_idx_nx[ADDR_W-1:0];
         sen      <= (state_nx != ST_SHIFT);
         S1_done  <= (state_nx == ST_DONE);
      end
   end

   always_comb begin
      state_nx    = state;
      word_idx_nx = word_idx;
      bit_cnt_nx  = bit_cnt;
      wait_cnt_nx = wait_cnt;
      load        = 1'b0;
      shift_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            word_idx_nx = '0;
            wait_cnt_nx = '0;
            state_nx    = ST_FETCH;
         end
         ST_FETCH: begin
            if (wait_cnt == WAIT_W'(RD_WAIT - 1)) begin
               wait_cnt_nx = '0;
               state_nx    = ST_LOAD;
            end else begin
               wait_cnt_nx = wait_cnt + 1'b1;
            end
         end
         ST_LOAD: begin
            load       = 1'b1;
            bit_cnt_nx = '0;
            state_nx   = ST_SHIFT;
         end
         ST_SHIFT: begin
            shift_en = 1'b1;
            if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
               wait_cnt_nx = '0;
               state_nx    = ST_GAP;
            end else begin
               bit_cnt_nx = bit_cnt + 1'b1;
            end
         end
         ST_GAP: begin
            if (wait_cnt == WAIT_W'(GAP_CYC - 1)) begin
               wait_cnt_nx = '0;
               word_idx_nx = word_inc;
               state_nx    = (word_inc == (ADDR_W+1)'(NUM_WORDS)) ? ST_DONE : ST_FETCH;
            end else begin
               wait_cnt_nx = wait_cnt + 1'b1;
            end
         end
         ST_DONE: begin
            state_nx = ST_DONE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // The shifter's MSB is a register bit and reads zero outside SHIFT, so it drives sd directly.
   s1_serial_tx_piso #(
      .FRAME_W (FRAME_W)
   ) u_piso (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .shift_en (shift_en),
      .din      ({word_idx[ADDR_W-1:0], RB1_Q}),
      .msb      (sd)
   );

endmodule

// File: tb/tb_s1_serial_tx.sv
// Bench for s1_serial_tx: a default instance and a GAP_CYC=1 / RD_WAIT=3 instance share one RB1
// image and reset, and are compared every cycle against a timeline model of the frame schedule.
module tb_s1_serial_tx;

   localparam int NW = 8;
   localparam int AW = 3;
   localparam int DW = 18;
   localparam int FW = AW + DW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [DW-1:0] mem [NW];
   logic [DW-1:0] q0, q1;
   logic [AW-1:0] a0, a1;
   logic          rw0, rw1, sen0, sen1, sd0, sd1, done0, done1;

   assign q0 = mem[a0];
   assign q1 = mem[a1];

   s1_serial_tx u_dut (
      .clk(clk), .rst(rst), .RB1_Q(q0), .RB1_RW(rw0), .RB1_A(a0),
      .sen(sen0), .sd(sd0), .S1_done(done0)
   );

   s1_serial_tx #(.GAP_CYC(1), .RD_WAIT(3)) u_sweep (
      .clk(clk), .rst(rst), .RB1_Q(q1), .RB1_RW(rw1), .RB1_A(a1),
      .sen(sen1), .sd(sd1), .S1_done(done1)
   );

   int checks = 0;
   int errors = 0;
   int t;
   logic running = 1'b0;

   // t counts rising edges since the last reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) t <= 0;
      else     t <= t + 1;
   end

   // Expected {RB1_RW, S1_done, sen, sd, RB1_A} after edge tt, derived from the packet timeline:
   // one idle cycle, then per word rdw fetch + 1 load + FW shift + gap cycles.
   function automatic logic [6:0] model(int tt, int gap, int rdw);
      int per;
      int i;
      int off;
      logic [FW-1:0] fr;
      per = rdw + 1 + FW + gap;
      if (tt < 1) return {1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
      if (tt >= 1 + NW * per) return {1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
      i   = (tt - 1) / per;
      off = (tt - 1) % per;
      fr  = {3'(i), mem[i]};
      if (off >= rdw + 1 && off < rdw + 1 + FW)
         return {1'b1, 1'b0, 1'b0, fr[FW - 1 - (off - rdw - 1)], 3'(i)};
      return {1'b1, 1'b0, 1'b1, 1'b0, 3'(i)};
   endfunction

   task automatic chk_vec(string name, logic [6:0] act, logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d rw/done/sen/sd/a got %b required %b", name, t, act, exp);
      end
   endtask

   task automatic chk_lit(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s t=%0d got 'h%0h required 'h%0h", name, t, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && running) begin
         chk_vec("model_dut",   {rw0, done0, sen0, sd0, a0}, model(t, 2, 1));
         chk_vec("model_sweep", {rw1, done1, sen1, sd1, a1}, model(t, 1, 3));
      end
   end

   initial begin
      int cnt;
      int guard;
      int j;
      logic [FW-1:0] fr;

      for (int i = 0; i < NW; i++) mem[i] = 18'(32'h13579 * (i + 3));
      mem[0] = 18'h2AAAA;

      // Reset held five cycles: all outputs at reset values throughout.
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk_vec("reset_dut",   {rw0, done0, sen0, sd0, a0}, 7'b1_0_1_0_000);
         chk_vec("reset_sweep", {rw1, done1, sen1, sd1, a1}, 7'b1_0_1_0_000);
      end
      #1 rst = 1'b0;
      running = 1'b1;

      // First frame of the default instance, bit by bit.
      cnt = 0;
      fr  = '0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (!sen0) begin
            fr = {fr[FW-2:0], sd0};
            cnt++;
         end else if (cnt > 0) begin
            break;
         end
      end
      chk_lit("frame0_bits", int'(fr), 32'h02AAAA);
      chk_lit("frame0_len", cnt, 21);

      // Reset in the middle of frame 3, at bit 10.
      guard = 0;
      while (t != 88 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk_lit("reach_frame3_bit10", t, 88);
      chk_lit("frame3_sen_low", int'(sen0), 0);
      #1 rst = 1'b1;
      #1;
      chk_lit("midrst_sen",   int'(sen0), 1);
      chk_lit("midrst_sd",    int'(sd0), 0);
      chk_lit("midrst_addr",  int'(a0), 0);
      chk_lit("midrst_sweep", int'(sen1), 1);

      for (int i = 0; i < NW; i++) mem[i] = 18'(1 << i);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;

      // Full run with one-hot data: frames in address order, completion timing.
      j   = 0;
      cnt = 0;
      fr  = '0;
      for (int n = 0; n < 230; n++) begin
         @(negedge clk);
         if (t == 200) chk_lit("done_before_201", int'(done0), 0);
         if (t == 201) chk_lit("done_at_201", int'(done0), 1);
         if (t == 208) chk_lit("sweep_done_before_209", int'(done1), 0);
         if (t == 209) chk_lit("sweep_done_at_209", int'(done1), 1);
         if (!sen0) begin
            fr = {fr[FW-2:0], sd0};
            cnt++;
         end else if (cnt > 0) begin
            chk_lit($sformatf("run_frame%0d", j), int'(fr), int'({3'(j), 18'(1 << j)}));
            chk_lit($sformatf("run_len%0d", j), cnt, 21);
            j++;
            cnt = 0;
         end
      end
      chk_lit("run_frame_count", j, 8);
      chk_lit("done_held", int'(done0), 1);

      running = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
